// File: rtl/noc_pkg.sv
// noc_pkg: definitions shared by the mesh tiles and the network injector.
//   FLIT_W        flit width (2-bit type + 32-bit payload)
//   FLIT_*        flit type codes carried in bits [33:32]
//   HEAD_*        field positions inside a head flit
//   inj_state_e   injector FSM states
//   make_head     assembles a head flit from its fields
package noc_pkg;

   localparam int FLIT_W    = 34;
   localparam int PAYLOAD_W = 32;

   localparam logic [1:0] FLIT_IDLE = 2'b00;
   localparam logic [1:0] FLIT_HEAD = 2'b01;
   localparam logic [1:0] FLIT_BODY = 2'b10;
   localparam logic [1:0] FLIT_TAIL = 2'b11;

   localparam int TYPE_MSB      = 33;
   localparam int TYPE_LSB      = 32;
   localparam int HEAD_DEST_MSB = 31;
   localparam int HEAD_DEST_LSB = 30;
   localparam int HEAD_SRC_MSB  = 29;
   localparam int HEAD_SRC_LSB  = 28;
   localparam int HEAD_SEQ_MSB  = 27;
   localparam int HEAD_SEQ_LSB  = 20;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BODY = 1'b1
   } inj_state_e;

   function automatic logic [FLIT_W-1:0] make_head(input logic [1:0] dest,
                                                   input logic [1:0] src,
                                                   input logic [7:0] seq);
      logic [FLIT_W-1:0] f;
      f = '0;
      f[TYPE_MSB:TYPE_LSB]           = FLIT_HEAD;
      f[HEAD_DEST_MSB:HEAD_DEST_LSB] = dest;
      f[HEAD_SRC_MSB:HEAD_SRC_LSB]   = src;
      f[HEAD_SEQ_MSB:HEAD_SEQ_LSB]   = seq;
      return f;
   endfunction

endpackage

// File: rtl/noc_fifo.sv
// noc_fifo: synchronous FIFO for the injector's payload-word buffer.
//   clk, rst       clock, asynchronous active-low reset
//   i_push/i_wr_data  write strobe and data (ignored when full)
//   i_pop          read strobe (ignored when empty)
//   o_rd_data      head entry, valid whenever !o_empty (show-ahead)
//   o_full/o_empty occupancy flags, derived from registers only
module noc_fifo #(
   parameter int WIDTH = 35,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
   end

endmodule

// File: rtl/noc_inject.sv
// noc_inject: serialises core payload words into head/body/tail flits on the
// tile's local link, with credit-based flow control.
//   clk, rst         clock, asynchronous active-low reset
//   in_valid/in_ready/in_data/in_last/in_dest  core payload stream
//   flit_out         registered flit, zero when idle
//   credit_in        one-cycle pulse per freed downstream slot
//   busy             packet in flight (head sent, tail not yet)
//   credit_err       sticky: credit returned while count already full
//
// state   | meaning
// ST_IDLE | between packets; next send is a head flit
// ST_BODY | head sent; sending body words until the tail
module noc_inject
   import noc_pkg::*;
#(
   parameter logic [1:0] TILE_ID    = 2'b00,
   parameter int         FIFO_DEPTH = 4,
   parameter int         CREDITS    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_data,
   input  logic              in_last,
   input  logic [1:0]        in_dest,
   output logic [FLIT_W-1:0] flit_out,
   input  logic              credit_in,
   output logic              busy,
   output logic              credit_err
);

   localparam int            CW        = $clog2(CREDITS + 1);
   localparam logic [CW-1:0] CRED_MAX  = CW'(CREDITS);
   localparam logic [CW-1:0] CRED_ONE  = CW'(1);
   localparam int            ENTRY_W   = 2 + 1 + PAYLOAD_W;

   inj_state_e          r_state;
   inj_state_e          w_state_nxt;
   logic [FLIT_W-1:0]   r_flit;
   logic [FLIT_W-1:0]   w_flit_nxt;
   logic [CW-1:0]       r_credits;
   logic                r_credit_err;
   logic [7:0]          r_seq;
   logic                r_first;
   logic [1:0]          r_dest;

   logic                w_push;
   logic                w_pop;
   logic                w_tail;
   logic                w_send;
   logic                w_fifo_full;
   logic                w_fifo_empty;
   logic [ENTRY_W-1:0]  w_fifo_rd;
   logic [1:0]          w_wr_dest;

   assign in_ready   = !w_fifo_full;
   assign w_push     = in_valid && in_ready;
   // Only the first word of a packet samples in_dest; the rest reuse it.
   assign w_wr_dest  = r_first ? in_dest : r_dest;
   assign w_send     = !w_fifo_empty && (r_credits != '0);
   assign flit_out   = r_flit;
   assign busy       = (r_state == ST_BODY);
   assign credit_err = r_credit_err;

   noc_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_push    (w_push),
      .i_wr_data ({w_wr_dest, in_last, in_data}),
      .i_pop     (w_pop),
      .o_rd_data (w_fifo_rd),
      .o_full    (w_fifo_full),
      .o_empty   (w_fifo_empty)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_state_nxt;
   end

   // The head flit peeks at the FIFO head entry without popping it; the same
   // entry then goes out as the first body/tail flit.
   always_comb begin
      w_state_nxt = r_state;
      w_flit_nxt  = '0;
      w_pop       = 1'b0;
      w_tail      = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_send) begin
               w_flit_nxt  = make_head(w_fifo_rd[ENTRY_W-1 -: 2], TILE_ID, r_seq);
               w_state_nxt = ST_BODY;
            end
         end
         ST_BODY: begin
            if (w_send) begin
               w_pop = 1'b1;
               if (w_fifo_rd[PAYLOAD_W]) begin
                  w_flit_nxt  = {FLIT_TAIL, w_fifo_rd[PAYLOAD_W-1:0]};
                  w_tail      = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_flit_nxt  = {FLIT_BODY, w_fifo_rd[PAYLOAD_W-1:0]};
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_flit       <= '0;
         r_credits    <= CRED_MAX;
         r_credit_err <= 1'b0;
         r_seq        <= '0;
         r_first      <= 1'b1;
         r_dest       <= '0;
      end else begin
         r_flit <= w_flit_nxt;
         // A send and a returned credit in the same cycle cancel out.
         unique case ({w_send, credit_in})
            2'b10: r_credits <= r_credits - CRED_ONE;
            2'b01: begin
               if (r_credits == CRED_MAX) r_credit_err <= 1'b1;
               else                       r_credits    <= r_credits + CRED_ONE;
            end
            default: r_credits <= r_credits;
         endcase
         if (w_tail) r_seq <= r_seq + 8'd1;
         if (w_push) begin
            r_first <= in_last;
            if (r_first) r_dest <= in_dest;
         end
      end
   end

endmodule

// File: tb/tb_noc_inject.sv
module tb_noc_inject;

   typedef struct {
      logic [33:0] flit;
      bit          consec;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic        in_last = 1'b0;
   logic [1:0]  in_dest = '0;
   logic [33:0] flit_out;
   logic        credit_in = 1'b0;
   logic        busy;
   logic        credit_err;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int flit_cnt = 0;
   int outstanding = 0;
   int busy_cnt = 0;
   int head_cyc = -1;
   int last_cyc = -100;
   int acc_cyc = 0;
   int accepts = 0;
   exp_t exp_q[$];
   exp_t e;

   noc_inject #(.TILE_ID(2'b00), .FIFO_DEPTH(4), .CREDITS(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .in_dest(in_dest),
      .flit_out(flit_out), .credit_in(credit_in), .busy(busy),
      .credit_err(credit_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [33:0] tb_head(input logic [1:0] dest, input logic [7:0] seq);
      return {2'b01, dest, 2'b00, seq, 20'h0};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [33:0] f, input bit consec);
      exp_t x;
      x.flit = f;
      x.consec = consec;
      exp_q.push_back(x);
   endtask

   // Monitor: every non-idle flit is matched against the scoreboard queue.
   always @(negedge clk) begin
      if (busy) busy_cnt++;
      if (flit_out !== '0) begin
         flit_cnt++;
         outstanding++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_flit: got %0h expected none", flit_out);
         end else begin
            e = exp_q.pop_front();
            chk("flit_value", 64'(flit_out), 64'(e.flit));
            if (e.consec) chk("flit_gap", 64'(cyc - last_cyc), 64'd1);
         end
         if (flit_out[33:32] == 2'b01) head_cyc = cyc;
         last_cyc = cyc;
      end
   end

   task automatic align();
      @(posedge clk); #1;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk); #1;
   endtask

   task automatic push_word(input logic [31:0] d, input logic last, input logic [1:0] dest);
      bit ok = 0;
      in_valid = 1'b1; in_data = d; in_last = last; in_dest = dest;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; acc_cyc = cyc; break; end
      end
      if (!ok) begin
         checks++; failures++;
         $display("FAIL push_timeout: got in_ready=0 expected accept");
         in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (ok) accepts++;
   endtask

   task automatic wait_flits(input int target, input int budget, input string name);
      bit ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (flit_cnt >= target) begin ok = 1; break; end
      end
      if (!ok) begin
         checks++; failures++;
         $display("FAIL %s_timeout: got %0d flits expected %0d", name, flit_cnt, target);
      end
   endtask

   task automatic credit_pulse();
      credit_in = 1'b1;
      @(posedge clk); #1;
      credit_in = 1'b0;
      outstanding--;
   endtask

   task automatic return_all();
      while (outstanding > 0) credit_pulse();
      wait_cyc(2);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      int base_acc;
      int a1;
      bit ok;

      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      align();
      sample();
      chk("rst_flit", 64'(flit_out), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd1);
      chk("rst_credit_err", 64'(credit_err), 64'd0);
      align();

      // Single-word packet
      base = flit_cnt; busy_cnt = 0;
      push_exp(tb_head(2'b11, 8'd0), 0);
      push_exp({2'b11, 32'hCAFE_0001}, 1);
      push_word(32'hCAFE_0001, 1'b1, 2'b11);
      in_valid = 1'b0;
      a1 = acc_cyc;
      wait_flits(base + 2, 20, "t1");
      wait_cyc(3);
      sample();
      chk("t1_count", 64'(flit_cnt - base), 64'd2);
      chk("t1_head_latency", 64'(head_cyc - a1), 64'd2);
      chk("t1_busy_cycles", 64'(busy_cnt), 64'd1);
      chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);
      align();
      return_all();

      // Four-word packet, valid held, dest change on word 2 ignored;
      // a credit arrives in the same cycle as a send.
      base = flit_cnt;
      push_exp(tb_head(2'b01, 8'd1), 0);
      push_exp({2'b10, 32'hA000_0001}, 1);
      push_exp({2'b10, 32'hA000_0002}, 1);
      push_exp({2'b10, 32'hA000_0003}, 1);
      push_exp({2'b11, 32'hA000_0004}, 1);
      fork
         begin
            push_word(32'hA000_0001, 1'b0, 2'b01);
            push_word(32'hA000_0002, 1'b0, 2'b10);
            push_word(32'hA000_0003, 1'b0, 2'b10);
            push_word(32'hA000_0004, 1'b1, 2'b10);
            in_valid = 1'b0;
         end
         begin
            wait_flits(base + 1, 20, "t2_head");
            align();
            credit_pulse();
         end
      join
      wait_cyc(4);
      sample();
      chk("t2_count", 64'(flit_cnt - base), 64'd5);
      chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);
      align();
      return_all();

      // Credit returned at full count
      sample();
      chk("t4_err_clear", 64'(credit_err), 64'd0);
      align();
      credit_pulse();
      outstanding++;
      sample();
      chk("t4_err_set", 64'(credit_err), 64'd1);
      align();
      wait_cyc(3);
      sample();
      chk("t4_err_sticky", 64'(credit_err), 64'd1);
      align();

      // Credit starvation on a 6-word packet
      base = flit_cnt;
      push_exp(tb_head(2'b10, 8'd2), 0);
      push_exp({2'b10, 32'hB000_0001}, 1);
      push_exp({2'b10, 32'hB000_0002}, 1);
      push_exp({2'b10, 32'hB000_0003}, 1);
      push_exp({2'b10, 32'hB000_0004}, 0);
      push_exp({2'b10, 32'hB000_0005}, 0);
      push_exp({2'b11, 32'hB000_0006}, 0);
      fork
         begin
            for (int i = 1; i <= 6; i++)
               push_word(32'hB000_0000 + 32'(i), (i == 6), 2'b10);
            in_valid = 1'b0;
         end
         begin
            wait_flits(base + 4, 30, "t3_first4");
            align();
            wait_cyc(6);
            sample();
            chk("t3_stalled_count", 64'(flit_cnt - base), 64'd4);
            chk("t3_stalled_busy", 64'(busy), 64'd1);
            align();
            credit_pulse();
            wait_cyc(4);
            sample();
            chk("t3_one_credit_one_flit", 64'(flit_cnt - base), 64'd5);
            align();
            credit_pulse();
            credit_pulse();
            wait_cyc(4);
            sample();
            chk("t3_done_count", 64'(flit_cnt - base), 64'd7);
            chk("t3_done_busy", 64'(busy), 64'd0);
            align();
         end
      join

      // Backpressure with zero credits
      base = flit_cnt; base_acc = accepts;
      push_exp(tb_head(2'b01, 8'd3), 0);
      for (int i = 1; i <= 5; i++) push_exp({2'b10, 32'hC000_0000 + 32'(i)}, 0);
      push_exp({2'b11, 32'hC000_0006}, 0);
      fork
         begin
            for (int i = 1; i <= 6; i++)
               push_word(32'hC000_0000 + 32'(i), (i == 6), 2'b01);
            in_valid = 1'b0;
         end
         begin
            ok = 0;
            for (int i = 0; i < 50; i++) begin
               @(negedge clk); #1;
               if (accepts - base_acc >= 4) begin ok = 1; break; end
            end
            if (!ok) begin
               checks++; failures++;
               $display("FAIL t5_accept_timeout: got %0d accepts expected 4", accepts - base_acc);
            end
            align();
            wait_cyc(3);
            sample();
            chk("t5_full_ready", 64'(in_ready), 64'd0);
            chk("t5_accepts", 64'(accepts - base_acc), 64'd4);
            chk("t5_no_flit_zero_credit", 64'(flit_cnt - base), 64'd0);
            align();
            credit_pulse();
            wait_cyc(3);
            sample();
            chk("t5_head_only", 64'(flit_cnt - base), 64'd1);
            chk("t5_head_no_pop", 64'(in_ready), 64'd0);
            align();
            credit_in = 1'b1;
            @(posedge clk); #1;
            credit_in = 1'b0;
            outstanding--;
            sample();
            chk("t5_ready_pop_cycle", 64'(in_ready), 64'd0);
            sample();
            chk("t5_ready_after_pop", 64'(in_ready), 64'd1);
            align();
            repeat (5) credit_pulse();
            wait_cyc(6);
            sample();
            chk("t5_done_count", 64'(flit_cnt - base), 64'd7);
            chk("t5_done_accepts", 64'(accepts - base_acc), 64'd6);
            chk("t5_done_busy", 64'(busy), 64'd0);
            align();
         end
      join
      return_all();

      // Reset mid-packet after head and one body
      base = flit_cnt;
      push_exp(tb_head(2'b10, 8'd4), 0);
      push_exp({2'b10, 32'hD000_0001}, 1);
      push_word(32'hD000_0001, 1'b0, 2'b10);
      in_valid = 1'b0;
      wait_flits(base + 2, 20, "t6_partial");
      #1 rst = 1'b0;
      #1;
      chk("t6_rst_flit", 64'(flit_out), 64'd0);
      chk("t6_rst_busy", 64'(busy), 64'd0);
      chk("t6_rst_ready", 64'(in_ready), 64'd1);
      chk("t6_rst_credit_err", 64'(credit_err), 64'd0);
      chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      outstanding = 0;
      base = flit_cnt;
      align();
      wait_cyc(3);
      sample();
      chk("t6_no_tail", 64'(flit_cnt - base), 64'd0);
      align();
      push_exp(tb_head(2'b01, 8'd0), 0);
      push_exp({2'b11, 32'hE000_0001}, 1);
      push_word(32'hE000_0001, 1'b1, 2'b01);
      in_valid = 1'b0;
      wait_flits(base + 2, 20, "t6_next");
      align();
      wait_cyc(2);
      sample();
      chk("t6_next_count", 64'(flit_cnt - base), 64'd2);
      chk("t6_next_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
